hazard_stall_unit: RTL and testbench

- ID-stage hazard detector and pipeline stall/flush controller for the 5-stage MIPS pipeline.
- Covers the hazards the EX-stage forwarding path cannot resolve:
  - load-use;
  - ALU-result or load result feeding an ID-resolved branch;
  - data-memory wait.
- Drives PC/IF_ID write enables, ID_EX bubble insertion, IF flush and a global freeze.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_unit.sv | 124 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detector and stall/flush controller for the 5-stage pipeline.
// Detects load-use hazards, ALU or load results feeding an ID-resolved branch,
// and data-memory waits. Drives the PC/IF_ID enables, ID_EX bubble, IF flush
// and global freeze, and counts stalled cycles in a saturating counter.
//
// Handshake note: this block has no valid/ready pairs. dmem_busy_i acts as a
// level "not ready" from data memory. While it is high, every pipeline
// register holds (freeze_o=1) and no state advances.
module hazard_stall_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_RS_i,
    input  logic [4:0]       IF_ID_RT_i,
    input  logic             ID_UsesRT_i,
    input  logic             ID_Branch_i,
    input  logic             Branch_taken_i,
    input  logic             Jump_i,
    input  logic             ID_EX_MemRead_i,
    input  logic             ID_EX_RegWrite_i,
    input  logic [4:0]       ID_EX_RD_i,
    input  logic             EX_MEM_MemRead_i,
    input  logic [4:0]       EX_MEM_RD_i,
    input  logic             dmem_busy_i,
    input  logic             stat_clr_i,
    output logic             PC_write_o,
    output logic             IF_ID_write_o,
    output logic             ID_EX_bubble_o,
    output logic             IF_flush_o,
    output logic             freeze_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic             state_dbg_o
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        LB_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_hit_e;
    logic w_hit_m;
    logic w_stall_a;
    logic w_stall_b;
    logic w_stall_c;
    logic w_data_stall;

    // Register 0 is hard-wired, so it never creates a dependency.
    assign w_hit_e = (ID_EX_RD_i != 5'd0) &&
                     ((ID_EX_RD_i == IF_ID_RS_i) ||
                      (ID_UsesRT_i && (ID_EX_RD_i == IF_ID_RT_i)));
    assign w_hit_m = (EX_MEM_RD_i != 5'd0) &&
                     ((EX_MEM_RD_i == IF_ID_RS_i) ||
                      (ID_UsesRT_i && (EX_MEM_RD_i == IF_ID_RT_i)));

    assign w_stall_a    = ID_EX_MemRead_i && w_hit_e;
    assign w_stall_b    = ID_Branch_i && ID_EX_RegWrite_i && w_hit_e;
    assign w_stall_c    = ID_Branch_i && EX_MEM_MemRead_i && w_hit_m;
    assign w_data_stall = w_stall_a || w_stall_b || w_stall_c;

    // Next state and outputs. Priority is reset, then freeze, then stall, then flush.
    always_comb begin
        w_state_nxt    = r_state;
        PC_write_o     = 1'b1;
        IF_ID_write_o  = 1'b1;
        ID_EX_bubble_o = 1'b0;
        IF_flush_o     = 1'b0;
        freeze_o       = 1'b0;
        if (!rst_i) begin
            w_state_nxt    = RUN;
            PC_write_o     = 1'b0;
            IF_ID_write_o  = 1'b0;
            ID_EX_bubble_o = 1'b1;
        end else if (dmem_busy_i) begin
            // Hold everything; any pending hazard is re-evaluated afterwards.
            freeze_o      = 1'b1;
            PC_write_o    = 1'b0;
            IF_ID_write_o = 1'b0;
        end else if (r_state == LB_HOLD) begin
            PC_write_o     = 1'b0;
            IF_ID_write_o  = 1'b0;
            ID_EX_bubble_o = 1'b1;
            w_state_nxt    = RUN;
        end else if (w_data_stall) begin
            // Branch/jump outcome is ignored because the operands are stale.
            PC_write_o     = 1'b0;
            IF_ID_write_o  = 1'b0;
            ID_EX_bubble_o = 1'b1;
            if (w_stall_a && ID_Branch_i) begin
                w_state_nxt = LB_HOLD;
            end
        end else begin
            IF_flush_o = (ID_Branch_i && Branch_taken_i) || Jump_i;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Saturating count of cycles with PC_write_o low; clear wins over increment.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cycles <= '0;
        end else if (stat_clr_i) begin
            r_stall_cycles <= '0;
        end else if (!PC_write_o && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles_o = r_stall_cycles;
    assign state_dbg_o    = r_state;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed testbench for hazard_stall_unit. Two instances share stimulus:
// the default 16-bit counter and a 4-bit counter for saturation.
module tb_hazard_stall_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  IF_ID_RS_i;
    logic [4:0]  IF_ID_RT_i;
    logic        ID_UsesRT_i;
    logic        ID_Branch_i;
    logic        Branch_taken_i;
    logic        Jump_i;
    logic        ID_EX_MemRead_i;
    logic        ID_EX_RegWrite_i;
    logic [4:0]  ID_EX_RD_i;
    logic        EX_MEM_MemRead_i;
    logic [4:0]  EX_MEM_RD_i;
    logic        dmem_busy_i;
    logic        stat_clr_i;
    logic        PC_write_o;
    logic        IF_ID_write_o;
    logic        ID_EX_bubble_o;
    logic        IF_flush_o;
    logic        freeze_o;
    logic [15:0] stall_cycles_o;
    logic        state_dbg_o;
    logic        PC_write_4;
    logic        IF_ID_write_4;
    logic        ID_EX_bubble_4;
    logic        IF_flush_4;
    logic        freeze_4;
    logic [3:0]  stall_cycles_4;
    logic        state_dbg_4;

    logic [4:0]  outs;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    localparam logic [4:0] O_RUN    = 5'b11000;
    localparam logic [4:0] O_FLUSH  = 5'b11010;
    localparam logic [4:0] O_STALL  = 5'b00100;
    localparam logic [4:0] O_FREEZE = 5'b00001;
    localparam logic [4:0] O_RESET  = 5'b00100;

    assign outs = {PC_write_o, IF_ID_write_o, ID_EX_bubble_o, IF_flush_o, freeze_o};

    // Clock generation.
    always #5 clk_i = ~clk_i;

    hazard_stall_unit dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .IF_ID_RS_i(IF_ID_RS_i), .IF_ID_RT_i(IF_ID_RT_i),
        .ID_UsesRT_i(ID_UsesRT_i), .ID_Branch_i(ID_Branch_i),
        .Branch_taken_i(Branch_taken_i), .Jump_i(Jump_i),
        .ID_EX_MemRead_i(ID_EX_MemRead_i), .ID_EX_RegWrite_i(ID_EX_RegWrite_i),
        .ID_EX_RD_i(ID_EX_RD_i), .EX_MEM_MemRead_i(EX_MEM_MemRead_i),
        .EX_MEM_RD_i(EX_MEM_RD_i), .dmem_busy_i(dmem_busy_i),
        .stat_clr_i(stat_clr_i),
        .PC_write_o(PC_write_o), .IF_ID_write_o(IF_ID_write_o),
        .ID_EX_bubble_o(ID_EX_bubble_o), .IF_flush_o(IF_flush_o),
        .freeze_o(freeze_o), .stall_cycles_o(stall_cycles_o),
        .state_dbg_o(state_dbg_o)
    );

    hazard_stall_unit #(.CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i),
        .IF_ID_RS_i(IF_ID_RS_i), .IF_ID_RT_i(IF_ID_RT_i),
        .ID_UsesRT_i(ID_UsesRT_i), .ID_Branch_i(ID_Branch_i),
        .Branch_taken_i(Branch_taken_i), .Jump_i(Jump_i),
        .ID_EX_MemRead_i(ID_EX_MemRead_i), .ID_EX_RegWrite_i(ID_EX_RegWrite_i),
        .ID_EX_RD_i(ID_EX_RD_i), .EX_MEM_MemRead_i(EX_MEM_MemRead_i),
        .EX_MEM_RD_i(EX_MEM_RD_i), .dmem_busy_i(dmem_busy_i),
        .stat_clr_i(stat_clr_i),
        .PC_write_o(PC_write_4), .IF_ID_write_o(IF_ID_write_4),
        .ID_EX_bubble_o(ID_EX_bubble_4), .IF_flush_o(IF_flush_4),
        .freeze_o(freeze_4), .stall_cycles_o(stall_cycles_4),
        .state_dbg_o(state_dbg_4)
    );

    // Advance one clock; inputs change and checks happen 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        IF_ID_RS_i = 5'd0; IF_ID_RT_i = 5'd0; ID_UsesRT_i = 1'b0;
        ID_Branch_i = 1'b0; Branch_taken_i = 1'b0; Jump_i = 1'b0;
        ID_EX_MemRead_i = 1'b0; ID_EX_RegWrite_i = 1'b0; ID_EX_RD_i = 5'd0;
        EX_MEM_MemRead_i = 1'b0; EX_MEM_RD_i = 5'd0;
        dmem_busy_i = 1'b0; stat_clr_i = 1'b0;
    endtask

    task automatic clear_counter();
        idle();
        stat_clr_i = 1'b1;
        step();
        stat_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1'b0;
        #2;
        vec_cnt++;
        if (outs !== O_RESET) begin
            err_cnt++; $display("FAIL reset_outs: got %b want %b", outs, O_RESET);
        end
        vec_cnt++;
        if (stall_cycles_o !== 16'd0 || state_dbg_o !== 1'b0) begin
            err_cnt++; $display("FAIL reset_state: cnt %0d st %b want 0 0", stall_cycles_o, state_dbg_o);
        end
        step();
        rst_i = 1'b1;
        #1;
        vec_cnt++;
        if (outs !== O_RUN) begin
            err_cnt++; $display("FAIL reset_release: got %b want %b", outs, O_RUN);
        end
        step();
    endtask

    task automatic test_load_use();
        clear_counter();
        ID_EX_MemRead_i = 1'b1; ID_EX_RegWrite_i = 1'b1; ID_EX_RD_i = 5'd2;
        IF_ID_RS_i = 5'd2; IF_ID_RT_i = 5'd4; ID_UsesRT_i = 1'b1;
        #1;
        vec_cnt++;
        if (outs !== O_STALL) begin
            err_cnt++; $display("FAIL lu_stall: got %b want %b", outs, O_STALL);
        end
        step();
        ID_EX_MemRead_i = 1'b0; ID_EX_RegWrite_i = 1'b0; ID_EX_RD_i = 5'd0;
        EX_MEM_MemRead_i = 1'b1; EX_MEM_RD_i = 5'd2;
        #1;
        vec_cnt++;
        if (outs !== O_RUN) begin
            err_cnt++; $display("FAIL lu_resume: got %b want %b", outs, O_RUN);
        end
        step();
        vec_cnt++;
        if (stall_cycles_o !== 16'd1) begin
            err_cnt++; $display("FAIL lu_count: got %0d want 1", stall_cycles_o);
        end
    endtask

    task automatic test_load_branch();
        clear_counter();
        ID_EX_MemRead_i = 1'b1; ID_EX_RegWrite_i = 1'b1; ID_EX_RD_i = 5'd2;
        IF_ID_RS_i = 5'd2; IF_ID_RT_i = 5'd5; ID_UsesRT_i = 1'b1;
        ID_Branch_i = 1'b1; Branch_taken_i = 1'b1;
        #1;
        vec_cnt++;
        if (outs !== O_STALL || state_dbg_o !== 1'b0) begin
            err_cnt++; $display("FAIL lb_stall1: got %b st %b want %b st 0", outs, state_dbg_o, O_STALL);
        end
        step();
        ID_EX_MemRead_i = 1'b0; ID_EX_RegWrite_i = 1'b0; ID_EX_RD_i = 5'd0;
        EX_MEM_MemRead_i = 1'b1; EX_MEM_RD_i = 5'd2;
        #1;
        vec_cnt++;
        if (outs !== O_STALL || state_dbg_o !== 1'b1) begin
            err_cnt++; $display("FAIL lb_stall2: got %b st %b want %b st 1", outs, state_dbg_o, O_STALL);
        end
        step();
        EX_MEM_MemRead_i = 1'b0; EX_MEM_RD_i = 5'd0;
        #1;
        vec_cnt++;
        if (outs !== O_FLUSH || state_dbg_o !== 1'b0) begin
            err_cnt++; $display("FAIL lb_flush: got %b st %b want %b st 0", outs, state_dbg_o, O_FLUSH);
        end
        vec_cnt++;
        if (stall_cycles_o !== 16'd2) begin
            err_cnt++; $display("FAIL lb_count: got %0d want 2", stall_cycles_o);
        end
        step();
    endtask

    task automatic test_alu_branch();
        clear_counter();
        ID_EX_RegWrite_i = 1'b1; ID_EX_RD_i = 5'd7;
        IF_ID_RS_i = 5'd0; IF_ID_RT_i = 5'd7; ID_UsesRT_i = 1'b1; ID_Branch_i = 1'b1;
        #1;
        vec_cnt++;
        if (outs !== O_STALL) begin
            err_cnt++; $display("FAIL ab_stall: got %b want %b", outs, O_STALL);
        end
        step();
        ID_EX_RegWrite_i = 1'b0; ID_EX_RD_i = 5'd0;
        #1;
        vec_cnt++;
        if (outs !== O_RUN || state_dbg_o !== 1'b0) begin
            err_cnt++; $display("FAIL ab_resume: got %b st %b want %b st 0", outs, state_dbg_o, O_RUN);
        end
        step();
        ID_EX_RegWrite_i = 1'b1; ID_EX_RD_i = 5'd0;
        IF_ID_RS_i = 5'd0; IF_ID_RT_i = 5'd0; Branch_taken_i = 1'b1;
        #1;
        vec_cnt++;
        if (outs !== O_FLUSH) begin
            err_cnt++; $display("FAIL ab_reg0: got %b want %b", outs, O_FLUSH);
        end
        step();
        vec_cnt++;
        if (stall_cycles_o !== 16'd1) begin
            err_cnt++; $display("FAIL ab_count: got %0d want 1", stall_cycles_o);
        end
    endtask

    task automatic test_freeze();
        clear_counter();
        ID_EX_MemRead_i = 1'b1; ID_EX_RegWrite_i = 1'b1; ID_EX_RD_i = 5'd2;
        IF_ID_RS_i = 5'd2; dmem_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec_cnt++;
            if (outs !== O_FREEZE) begin
                err_cnt++; $display("FAIL fz_cycle%0d: got %b want %b", i, outs, O_FREEZE);
            end
            step();
        end
        dmem_busy_i = 1'b0;
        #1;
        vec_cnt++;
        if (outs !== O_STALL) begin
            err_cnt++; $display("FAIL fz_stall: got %b want %b", outs, O_STALL);
        end
        step();
        ID_EX_MemRead_i = 1'b0; ID_EX_RegWrite_i = 1'b0; ID_EX_RD_i = 5'd0;
        #1;
        vec_cnt++;
        if (outs !== O_RUN) begin
            err_cnt++; $display("FAIL fz_resume: got %b want %b", outs, O_RUN);
        end
        step();
        vec_cnt++;
        if (stall_cycles_o !== 16'd4) begin
            err_cnt++; $display("FAIL fz_count: got %0d want 4", stall_cycles_o);
        end
    endtask

    task automatic test_jump();
        clear_counter();
        Jump_i = 1'b1;
        #1;
        vec_cnt++;
        if (outs !== O_FLUSH) begin
            err_cnt++; $display("FAIL jmp_flush: got %b want %b", outs, O_FLUSH);
        end
        ID_EX_MemRead_i = 1'b1; ID_EX_RegWrite_i = 1'b1; ID_EX_RD_i = 5'd9;
        IF_ID_RS_i = 5'd9;
        #1;
        vec_cnt++;
        if (outs !== O_STALL) begin
            err_cnt++; $display("FAIL jmp_lu_stall: got %b want %b", outs, O_STALL);
        end
        step();
        ID_EX_MemRead_i = 1'b0; ID_EX_RegWrite_i = 1'b0; ID_EX_RD_i = 5'd0;
        #1;
        vec_cnt++;
        if (outs !== O_FLUSH) begin
            err_cnt++; $display("FAIL jmp_lu_flush: got %b want %b", outs, O_FLUSH);
        end
        step();
        idle();
    endtask

    task automatic test_saturate();
        clear_counter();
        dmem_busy_i = 1'b1;
        for (int i = 0; i < 20; i++) step();
        vec_cnt++;
        if (stall_cycles_4 !== 4'd15) begin
            err_cnt++; $display("FAIL sat_cnt4: got %0d want 15", stall_cycles_4);
        end
        vec_cnt++;
        if (stall_cycles_o !== 16'd20) begin
            err_cnt++; $display("FAIL sat_cnt16: got %0d want 20", stall_cycles_o);
        end
        stat_clr_i = 1'b1;
        step();
        stat_clr_i = 1'b0;
        vec_cnt++;
        if (stall_cycles_4 !== 4'd0 || stall_cycles_o !== 16'd0) begin
            err_cnt++; $display("FAIL sat_clr: got %0d/%0d want 0/0", stall_cycles_4, stall_cycles_o);
        end
        idle();
        step();
    endtask

    task automatic test_reset_lb_hold();
        clear_counter();
        ID_EX_MemRead_i = 1'b1; ID_EX_RegWrite_i = 1'b1; ID_EX_RD_i = 5'd3;
        IF_ID_RS_i = 5'd3; ID_Branch_i = 1'b1; Branch_taken_i = 1'b1;
        step();
        ID_EX_MemRead_i = 1'b0; ID_EX_RegWrite_i = 1'b0; ID_EX_RD_i = 5'd0;
        #1;
        vec_cnt++;
        if (state_dbg_o !== 1'b1) begin
            err_cnt++; $display("FAIL rl_in_hold: got %b want 1", state_dbg_o);
        end
        rst_i = 1'b0;
        #1;
        vec_cnt++;
        if (outs !== O_RESET || state_dbg_o !== 1'b0 || stall_cycles_o !== 16'd0) begin
            err_cnt++; $display("FAIL rl_async: got %b st %b cnt %0d want %b st 0 cnt 0",
                                outs, state_dbg_o, stall_cycles_o, O_RESET);
        end
        step();
        ID_Branch_i = 1'b0; Branch_taken_i = 1'b0;
        rst_i = 1'b1;
        #1;
        vec_cnt++;
        if (outs !== O_RUN || state_dbg_o !== 1'b0) begin
            err_cnt++; $display("FAIL rl_release: got %b st %b want %b st 0", outs, state_dbg_o, O_RUN);
        end
        step();
        vec_cnt++;
        if (outs !== O_RUN || stall_cycles_o !== 16'd0) begin
            err_cnt++; $display("FAIL rl_no_carry: got %b cnt %0d want %b cnt 0", outs, stall_cycles_o, O_RUN);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_load_branch();
        test_alu_branch();
        test_freeze();
        test_jump();
        test_saturate();
        test_reset_lb_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
